// File: rtl/ex_stage.sv
// ex_stage: execute stage ALU with an optional restoring divider (enabled by EX_DIV_EN)
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic [31:0] logic_res, shift_res, arith_res;
  logic        is_div;

  assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);

  // Single-cycle ALU result per class, selected by alusel_i; outputs forced to 0 in reset
  always_comb begin
    logic_res = aluop_i == OP_OR  ? reg1_i | reg2_i :
                aluop_i == OP_AND ? reg1_i & reg2_i :
                aluop_i == OP_XOR ? reg1_i ^ reg2_i :
                aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : 32'd0;
    shift_res = aluop_i == OP_SLL ? reg2_i << reg1_i[4:0] :
                aluop_i == OP_SRL ? reg2_i >> reg1_i[4:0] :
                aluop_i == OP_SRA ? $unsigned($signed(reg2_i) >>> reg1_i[4:0]) : 32'd0;
    arith_res = aluop_i == OP_ADDU ? reg1_i + reg2_i :
                aluop_i == OP_SUBU ? reg1_i - reg2_i :
                aluop_i == OP_SLT  ? {31'd0, $signed(reg1_i) < $signed(reg2_i)} :
                aluop_i == OP_SLTU ? {31'd0, reg1_i < reg2_i} : 32'd0;
    wdata_o   = !rst ? 32'd0 :
                alusel_i == SEL_LOGIC ? logic_res :
                alusel_i == SEL_SHIFT ? shift_res :
                alusel_i == SEL_ARITH ? arith_res : 32'd0;
    wd_o      = rst ? wd_i : 5'd0;
    wreg_o    = rst && wreg_i && !is_div;
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [63:0] res_q, res_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic [32:0] trial;
  logic        fits, sgn;
  logic [31:0] rem_n, quo_n, a_abs, b_abs;

  // Divider state; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FREE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      res_q   <= 64'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits
  always_comb begin
    sgn   = aluop_i == OP_DIV;
    a_abs = sgn && reg1_i[31] ? -reg1_i : reg1_i;
    b_abs = sgn && reg2_i[31] ? -reg2_i : reg2_i;
    trial = {rem_q, quo_q[31]};
    fits  = trial >= {1'b0, dvs_q};
    rem_n = fits ? trial[31:0] - dvs_q : trial[31:0];
    quo_n = {quo_q[30:0], fits};
  end

  // Next-state: FREE detects a divide, ON iterates 32 steps and applies signs, END presents HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      FREE:
        if (is_div && !annul_i) begin
          if (reg2_i == 32'd0) state_d = BYZERO;
          else begin
            state_d = ON;
            cnt_d   = 5'd0;
            rem_d   = 32'd0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            negq_d  = sgn && (reg1_i[31] ^ reg2_i[31]);
            negr_d  = sgn && reg1_i[31];
          end
        end
      BYZERO: begin
        res_d   = 64'd0;
        state_d = END;
      end
      ON:
        if (annul_i) state_d = FREE;
        else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = END;
            res_d   = {negr_q ? -rem_n : rem_n, negq_q ? -quo_n : quo_n};
          end
        end
      default: state_d = FREE;
    endcase
  end

  // Stall until the result is ready; the END cycle carries the HI/LO write
  always_comb begin
    stallreq_o = rst && ((state_q == FREE && is_div && !annul_i) || state_q == BYZERO || state_q == ON);
    whilo_o    = rst && state_q == END;
    hi_o       = whilo_o ? res_q[63:32] : 32'd0;
    lo_o       = whilo_o ? res_q[31:0] : 32'd0;
  end
`else
  logic unused;

  assign unused = &{1'b0, clk, annul_i};

  // Without the divider, divides behave as nops and HI/LO is never written
  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
  end
`endif
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage (ALU paths, divider or divide-as-nop, resets)
module tb_ex_stage;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  aluop_i = OP_NOP;
  logic [2:0]  alusel_i = SEL_NOP;
  logic [31:0] reg1_i = '0, reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0, annul_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  int          tests = 0, fails = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .annul_i(annul_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(OP_OR, SEL_LOGIC, 32'h0000FF00, 32'h00FF0000);
    wd_i = 5'd5; wreg_i = 1'b1;
    #2;
    tests++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      fails++; $display("FAIL reset_outputs got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b exp all 0", wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    tick(); tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_logic();
    logic [7:0]  op [5] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_OR};
    logic [2:0]  sl [5] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_NOP};
    logic [31:0] a  [5] = '{32'h0000FF00, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'h12345678};
    logic [31:0] b  [5] = '{32'h00FF0000, 32'hFF00FF00, 32'hFF00FF00, 32'h0, 32'h1};
    logic [31:0] e  [5] = '{32'h00FFFF00, 32'hF000F000, 32'h0FF00FF0, 32'hFFFFFFFF, 32'h0};
    wd_i = 5'd5; wreg_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(op[i], sl[i], a[i], b[i]);
      #1;
      tests++;
      if (wdata_o !== e[i]) begin fails++; $display("FAIL logic[%0d] wdata got %h exp %h", i, wdata_o, e[i]); end
    end
    tests++;
    if ({wd_o, wreg_o, whilo_o} !== {5'd5, 1'b1, 1'b0}) begin
      fails++; $display("FAIL logic_passthru got wd=%0d wreg=%b whilo=%b exp wd=5 wreg=1 whilo=0", wd_o, wreg_o, whilo_o);
    end
    tick();
  endtask

  task automatic test_shift();
    logic [7:0]  op [5] = '{OP_SLL, OP_SRL, OP_SRA, OP_SRA, OP_SLL};
    logic [31:0] a  [5] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'h24};
    logic [31:0] b  [5] = '{32'h1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h1};
    logic [31:0] e  [5] = '{32'h10, 32'h08000000, 32'hF8000000, 32'h04000000, 32'h10};
    for (int i = 0; i < 5; i++) begin
      drive(op[i], SEL_SHIFT, a[i], b[i]);
      #1;
      tests++;
      if (wdata_o !== e[i]) begin fails++; $display("FAIL shift[%0d] wdata got %h exp %h", i, wdata_o, e[i]); end
    end
    tick();
  endtask

  task automatic test_arith();
    logic [7:0]  op [5] = '{OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_SLT};
    logic [31:0] a  [5] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
    logic [31:0] b  [5] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFF};
    logic [31:0] e  [5] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(op[i], SEL_ARITH, a[i], b[i]);
      #1;
      tests++;
      if (wdata_o !== e[i]) begin fails++; $display("FAIL arith[%0d] wdata got %h exp %h", i, wdata_o, e[i]); end
    end
    tick();
  endtask

`ifdef EX_DIV_EN
  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n = 0;
    wreg_i = 1'b1;
    drive(op, SEL_NOP, a, b);
    #1;
    tests++;
    if (wreg_o !== 1'b0) begin fails++; $display("FAIL %s wreg got %b exp 0", name, wreg_o); end
    while (stallreq_o === 1'b1 && n < 100) begin n++; tick(); end
    tests++;
    if (n !== 33) begin fails++; $display("FAIL %s stall_cycles got %0d exp 33", name, n); end
    tests++;
    if ({whilo_o, lo_o, hi_o} !== {1'b1, exp_lo, exp_hi}) begin
      fails++; $display("FAIL %s end got whilo=%b lo=%h hi=%h exp whilo=1 lo=%h hi=%h", name, whilo_o, lo_o, hi_o, exp_lo, exp_hi);
    end
    tick();
    aluop_i = OP_NOP;
    #1;
    tests++;
    if ({whilo_o, stallreq_o} !== 2'b00) begin fails++; $display("FAIL %s after_end got whilo=%b stall=%b exp 0 0", name, whilo_o, stallreq_o); end
  endtask

  task automatic test_div();
    run_div("div_signed", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu_100_3", OP_DIVU, 32'd100, 32'd3, 32'd33, 32'd1);
  endtask

  task automatic test_back_to_back();
    run_div("div_pos_neg", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
    run_div("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
  endtask

  task automatic test_div_byzero();
    drive(OP_DIVU, SEL_NOP, 32'd7, 32'd0);
    #1;
    tests++;
    if ({stallreq_o, whilo_o} !== 2'b10) begin fails++; $display("FAIL byzero_c1 got stall=%b whilo=%b exp 1 0", stallreq_o, whilo_o); end
    tick();
    tests++;
    if ({stallreq_o, whilo_o} !== 2'b10) begin fails++; $display("FAIL byzero_c2 got stall=%b whilo=%b exp 1 0", stallreq_o, whilo_o); end
    tick();
    tests++;
    if ({stallreq_o, whilo_o, hi_o, lo_o} !== {2'b01, 64'd0}) begin
      fails++; $display("FAIL byzero_c3 got stall=%b whilo=%b hi=%h lo=%h exp 0 1 0 0", stallreq_o, whilo_o, hi_o, lo_o);
    end
    aluop_i = OP_NOP;
    tick();
  endtask

  task automatic test_div_annul();
    int seen = 0;
    drive(OP_DIVU, SEL_NOP, 32'd100, 32'd3);
    for (int i = 0; i < 11; i++) tick();
    annul_i = 1'b1;
    #1;
    tick();
    aluop_i = OP_NOP;
    annul_i = 1'b0;
    #1;
    tests++;
    if ({stallreq_o, whilo_o} !== 2'b00) begin fails++; $display("FAIL annul_next got stall=%b whilo=%b exp 0 0", stallreq_o, whilo_o); end
    for (int i = 0; i < 40; i++) begin
      if (whilo_o === 1'b1 || stallreq_o === 1'b1) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL annul_quiet got %0d active cycles exp 0", seen); end
  endtask
`else
  task automatic test_div();
    int seen = 0;
    wreg_i = 1'b1;
    drive(OP_DIV, SEL_NOP, 32'hFFFFFFF9, 32'd2);
    #1;
    tests++;
    if ({stallreq_o, whilo_o, wreg_o, wdata_o} !== '0) begin
      fails++; $display("FAIL div_nop got stall=%b whilo=%b wreg=%b wdata=%h exp all 0", stallreq_o, whilo_o, wreg_o, wdata_o);
    end
    for (int i = 0; i < 40; i++) begin
      if (whilo_o === 1'b1 || stallreq_o === 1'b1) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL div_nop_quiet got %0d active cycles exp 0", seen); end
    drive(OP_DIVU, SEL_NOP, 32'd7, 32'd0);
    #1;
    tests++;
    if ({stallreq_o, whilo_o, hi_o, lo_o} !== '0) begin
      fails++; $display("FAIL divu_nop got stall=%b whilo=%b hi=%h lo=%h exp all 0", stallreq_o, whilo_o, hi_o, lo_o);
    end
    aluop_i = OP_NOP;
    tick();
  endtask
`endif

  task automatic test_reset_mid_div();
    int seen = 0;
    drive(OP_DIV, SEL_NOP, 32'hFFFFFFF9, 32'd2);
    wd_i = 5'd9; wreg_i = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b0;
    drive(OP_OR, SEL_LOGIC, 32'h1, 32'h2);
    #1;
    tests++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
      fails++; $display("FAIL midreset got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b exp all 0", wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    tick(); tick();
    rst = 1'b1;
    drive(OP_NOP, SEL_NOP, 32'h0, 32'h0);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (whilo_o === 1'b1 || stallreq_o === 1'b1) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL midreset_quiet got %0d active cycles exp 0", seen); end
    drive(OP_ADDU, SEL_ARITH, 32'd1, 32'd2);
    #1;
    tests++;
    if ({wdata_o, wd_o, wreg_o} !== {32'd3, 5'd9, 1'b1}) begin
      fails++; $display("FAIL midreset_addu got wdata=%h wd=%0d wreg=%b exp 3 9 1", wdata_o, wd_o, wreg_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_arith();
    test_div();
`ifdef EX_DIV_EN
    test_back_to_back();
    test_div_byzero();
    test_div_annul();
`endif
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
